// File: rtl/tdc_rx_pkg.sv
// Frame constants, receiver state encoding and output word layout shared by
// the TDC serial receiver and tdc_fw_core.
package tdc_rx_pkg;

    localparam int PAYLOAD_W = 24;
    localparam int ID_W      = 8;
    localparam int WORD_W    = ID_W + PAYLOAD_W;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [PAYLOAD_W-1:0] payload;
    } rx_word_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tdc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word and
// count-based full/empty; reports words dropped on a push into a full buffer.
module tdc_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic         o_empty,
    output logic [W-1:0] o_rdata,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic [W-1:0]  r_head;

    logic          w_pop, w_wr, w_bypass;
    logic [AW-1:0] w_rd_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  w_head_nxt;

    assign w_pop     = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head is leaving this cycle.
    assign w_wr      = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_drop    = i_push && !w_wr;
    assign w_rd_nxt  = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_cnt_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    // The incoming word becomes the head directly when nothing else remains.
    assign w_bypass   = w_wr && ((r_count - CW'(w_pop)) == '0);
    assign w_head_nxt = w_bypass ? i_wdata : r_mem[w_rd_nxt];

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            if (w_cnt_nxt != '0)
                r_head <= w_head_nxt;
        end
    end

    assign o_empty = r_empty;
    assign o_rdata = r_head;

endmodule

// File: rtl/tdc_rx_deser.sv
// Serial frame receiver for the tdc_top DATA_OUT line: deserialises 24-bit
// payloads into {IDENTIFIER, payload} words buffered in a FWFT FIFO.
// Optional even-parity bit enabled by defining TDC_RX_PARITY_EN.
module tdc_rx_deser
    import tdc_rx_pkg::*;
#(
    parameter int              FIFO_DEPTH = 8,
    parameter logic [ID_W-1:0] IDENTIFIER = 8'h01
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              ENABLE,
    input  logic              RX_CE,
    input  logic              RX_DATA,
    input  logic              FIFO_READ,
    output logic              FIFO_EMPTY,
    output logic [WORD_W-1:0] FIFO_DATA,
    output logic [7:0]        LOST_COUNT,
    output logic [7:0]        ERR_COUNT,
    input  logic              CLEAR_COUNTERS
);

    rx_state_t             r_state, w_state_nxt;
    logic [PAYLOAD_W-1:0]  r_shreg;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [7:0]            r_lost, r_err;

    logic     w_strobe, w_last_bit, w_start, w_shift, w_push, w_err, w_drop;
    rx_word_t w_word;

    assign w_strobe   = ENABLE && RX_CE;
    assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(PAYLOAD_W - 1));

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!ENABLE) begin
            w_state_nxt = ST_IDLE;
        end else if (RX_CE) begin
            case (r_state)
                ST_IDLE:  if (RX_DATA) w_state_nxt = ST_SHIFT;
`ifdef TDC_RX_PARITY_EN
                ST_SHIFT: if (w_last_bit) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = (RX_DATA == ^r_shreg) ? ST_STOP : ST_IDLE;
`else
                ST_SHIFT: if (w_last_bit) w_state_nxt = ST_STOP;
`endif
                ST_STOP:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start = w_strobe && (r_state == ST_IDLE) && RX_DATA;
        w_shift = w_strobe && (r_state == ST_SHIFT);
        w_push  = w_strobe && (r_state == ST_STOP) && !RX_DATA;
        w_err   = w_strobe && (r_state == ST_STOP) && RX_DATA;
`ifdef TDC_RX_PARITY_EN
        if (w_strobe && (r_state == ST_PARITY) && (RX_DATA != ^r_shreg))
            w_err = 1'b1;
`endif
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (!ENABLE || w_start) begin
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_shreg   <= {r_shreg[PAYLOAD_W-2:0], RX_DATA};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign w_word = '{id: IDENTIFIER, payload: r_shreg};

    tdc_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .i_clk   (BUS_CLK),
        .i_rst   (BUS_RST),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (FIFO_READ),
        .o_empty (FIFO_EMPTY),
        .o_rdata (FIFO_DATA),
        .o_drop  (w_drop)
    );

    // Clear takes priority so a clear coinciding with an event still reads 0.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_lost <= '0;
            r_err  <= '0;
        end else if (CLEAR_COUNTERS) begin
            r_lost <= '0;
            r_err  <= '0;
        end else begin
            if (w_drop) r_lost <= sat_inc8(r_lost);
            if (w_err)  r_err  <= sat_inc8(r_err);
        end
    end

    assign LOST_COUNT = r_lost;
    assign ERR_COUNT  = r_err;

endmodule

// File: tb/tb_tdc_rx_deser.sv
// Directed self-checking bench for tdc_rx_deser (default FIFO_DEPTH=8, ID 8'h01).
module tb_tdc_rx_deser;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST, ENABLE, RX_CE, RX_DATA, FIFO_READ, CLEAR_COUNTERS;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_COUNT, ERR_COUNT;

    int checks = 0;
    int errors = 0;
    int err_exp = 0;

    always #5 BUS_CLK = ~BUS_CLK;

    tdc_rx_deser #(.FIFO_DEPTH(8), .IDENTIFIER(8'h01)) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .ENABLE         (ENABLE),
        .RX_CE          (RX_CE),
        .RX_DATA        (RX_DATA),
        .FIFO_READ      (FIFO_READ),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_DATA      (FIFO_DATA),
        .LOST_COUNT     (LOST_COUNT),
        .ERR_COUNT      (ERR_COUNT),
        .CLEAR_COUNTERS (CLEAR_COUNTERS)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX_DATA = b;
        RX_CE   = 1'b1;
        step;
        RX_CE   = 1'b0;
        RX_DATA = 1'b0;
        step;
    endtask

    task automatic send_frame(input logic [23:0] p, input logic bad_stop);
        send_bit(1'b1);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
`ifdef TDC_RX_PARITY_EN
        send_bit(^p);
`endif
        send_bit(bad_stop);
    endtask

    task automatic pop;
        FIFO_READ = 1'b1;
        step;
        FIFO_READ = 1'b0;
    endtask

    task automatic pulse_clear;
        CLEAR_COUNTERS = 1'b1;
        step;
        CLEAR_COUNTERS = 1'b0;
    endtask

    initial begin
        BUS_RST = 1'b1; ENABLE = 1'b1; RX_CE = 1'b0; RX_DATA = 1'b0;
        FIFO_READ = 1'b0; CLEAR_COUNTERS = 1'b0;
        step; step;
        chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("rst_data",  FIFO_DATA,       32'h0);
        chk("rst_lost",  32'(LOST_COUNT), 32'd0);
        chk("rst_err",   32'(ERR_COUNT),  32'd0);
        BUS_RST = 1'b0;
        step;

        // Single good frame
        send_frame(24'hA5C3F0, 1'b0);
        chk("a5_empty", 32'(FIFO_EMPTY), 32'd0);
        chk("a5_data",  FIFO_DATA,       32'h01A5C3F0);
        chk("a5_lost",  32'(LOST_COUNT), 32'd0);
        chk("a5_err",   32'(ERR_COUNT),  32'd0);
        pop;
        chk("a5_popped", 32'(FIFO_EMPTY), 32'd1);

        // Read while empty must not disturb pointers
        pop;
        send_frame(24'h000ABC, 1'b0);
        chk("rdempty_data", FIFO_DATA, 32'h01000ABC);
        pop;
        chk("rdempty_empty", 32'(FIFO_EMPTY), 32'd1);

        // Overflow: 10 frames into depth 8
        for (int f = 0; f < 10; f++) send_frame(24'(f), 1'b0);
        chk("ovf_lost", 32'(LOST_COUNT), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_empty%0d", i), 32'(FIFO_EMPTY), 32'd0);
            chk($sformatf("ovf_data%0d", i),  FIFO_DATA, 32'h01000000 + 32'(i));
            pop;
        end
        chk("ovf_drained", 32'(FIFO_EMPTY), 32'd1);

        // Framing error
        send_frame(24'h5A5A5A, 1'b1);
        err_exp = 1;
        chk("frm_err",   32'(ERR_COUNT),  32'(err_exp));
        chk("frm_empty", 32'(FIFO_EMPTY), 32'd1);

`ifdef TDC_RX_PARITY_EN
        send_bit(1'b1);
        for (int i = 23; i >= 0; i--) send_bit(i == 0);
        send_bit(1'b0);
        send_bit(1'b0);
        err_exp = 2;
        chk("par_err",   32'(ERR_COUNT),  32'(err_exp));
        chk("par_empty", 32'(FIFO_EMPTY), 32'd1);
`endif

        // ENABLE dropped mid-frame
        send_bit(1'b1);
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        ENABLE = 1'b0;
        step; step;
        ENABLE = 1'b1;
        step;
        send_frame(24'h123456, 1'b0);
        chk("en_data", FIFO_DATA,       32'h01123456);
        chk("en_err",  32'(ERR_COUNT),  32'(err_exp));
        pop;
        chk("en_empty", 32'(FIFO_EMPTY), 32'd1);

        // Saturation and clear
        pulse_clear;
        chk("clr_lost", 32'(LOST_COUNT), 32'd0);
        chk("clr_err",  32'(ERR_COUNT),  32'd0);
        for (int f = 0; f < 300; f++) send_frame(24'h0F0F0F, 1'b1);
        chk("sat_err", 32'(ERR_COUNT), 32'd255);
        pulse_clear;
        chk("sat_clr", 32'(ERR_COUNT), 32'd0);

        // Reset mid-frame with 3 words buffered
        send_frame(24'h111111, 1'b0);
        send_frame(24'h222222, 1'b0);
        send_frame(24'h333333, 1'b0);
        send_frame(24'h444444, 1'b1);
        chk("pre_rst_data", FIFO_DATA,      32'h01111111);
        chk("pre_rst_err",  32'(ERR_COUNT), 32'd1);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2 BUS_RST = 1'b1;
        #1;
        chk("mrst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("mrst_data",  FIFO_DATA,       32'h0);
        chk("mrst_lost",  32'(LOST_COUNT), 32'd0);
        chk("mrst_err",   32'(ERR_COUNT),  32'd0);
        step;
        BUS_RST = 1'b0;
        step;
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        chk("post_rst_idle", 32'(FIFO_EMPTY), 32'd1);
        send_frame(24'hABCDEF, 1'b0);
        chk("post_rst_data", FIFO_DATA,      32'h01ABCDEF);
        chk("post_rst_err",  32'(ERR_COUNT), 32'd0);
        pop;
        chk("post_rst_empty", 32'(FIFO_EMPTY), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_rx_deser.md
TDC_RX_DESER -- requirements
Module: tdc_rx_deser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of 32-bit words buffered; power of two, 2..64.
REQ-002 SHALL have parameter IDENTIFIER, default 8'h01, placed in bits [31:24] of every output word.
REQ-003 SHALL have port BUS_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port BUS_RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ENABLE  input  1  receiver enable; low forces IDLE.
REQ-006 SHALL have port RX_CE  input  1  bit strobe, one BUS_CLK cycle high per serial bit period.
REQ-007 SHALL have port RX_DATA  input  1  serial DATA_OUT line from tdc_top, sampled only when RX_CE=1.
REQ-008 SHALL have port FIFO_READ  input  1  pop request.
REQ-009 SHALL have port FIFO_EMPTY  output  1  high when no word is buffered.
REQ-010 SHALL have port FIFO_DATA  output  32  head word, first-word-fall-through.
REQ-011 SHALL have port LOST_COUNT  output  8  words dropped on full FIFO, saturating.
REQ-012 SHALL have port ERR_COUNT  output  8  frames dropped on framing/parity error, saturating.
REQ-013 SHALL have port CLEAR_COUNTERS  input  1  one-cycle pulse zeroing LOST_COUNT and ERR_COUNT.

Function
REQ-014 SHALL treat the line as idle-low; a frame is start bit 1, 24 payload bits MSB first, optional parity bit (REQ-026), stop bit 0.
REQ-015 SHALL implement states IDLE, SHIFT, PARITY, STOP; transitions occur only on cycles with RX_CE=1 except ENABLE low.
REQ-016 SHALL move IDLE->SHIFT when RX_DATA=1 on an RX_CE cycle with ENABLE=1.
REQ-017 SHALL shift 24 bits in SHIFT using a 5-bit counter, then move to PARITY (macro defined) or STOP (macro undefined).
REQ-018 SHALL in STOP accept RX_DATA=0 as valid frame end and return to IDLE; RX_DATA=1 SHALL be a framing error, frame discarded, ERR_COUNT incremented, return to IDLE.
REQ-019 SHALL form word {IDENTIFIER, payload[23:0]} and have it at FIFO_DATA with FIFO_EMPTY low at most 2 BUS_CLK cycles after the valid stop-bit RX_CE cycle, when FIFO was empty.
REQ-020 SHALL pop on FIFO_READ=1 with FIFO_EMPTY=0; next word appears on the following cycle; FIFO_READ with FIFO_EMPTY=1 SHALL be ignored.
REQ-021 SHALL, on push with FIFO full and no simultaneous pop, discard the new word and increment LOST_COUNT; push and pop in the same cycle when full SHALL both succeed.
REQ-022 SHALL saturate both counters at 255; CLEAR_COUNTERS coinciding with an increment SHALL yield 0.
REQ-023 SHALL, on ENABLE deassertion, return to IDLE next cycle discarding any partial frame without counting an error; FIFO contents SHALL be kept and remain readable.

Reset
REQ-024 SHALL on BUS_RST asynchronously set state IDLE, shift register and bit counter 0, FIFO pointers 0, FIFO_EMPTY 1, FIFO_DATA 0, LOST_COUNT 0, ERR_COUNT 0.
REQ-025 SHALL, on BUS_RST asserted mid-frame, discard the frame; first frame after release requires a fresh start bit.

Configuration
REQ-026 SHALL use macro TDC_RX_PARITY_EN: defined -> 27-bit frame with even parity bit over the 24 payload bits, mismatch discards the frame and increments ERR_COUNT; undefined -> 26-bit frame, PARITY state and parity logic absent, ERR_COUNT counts framing errors only.

Structure
REQ-027 SHALL place frame constants (payload width 24, identifier width 8), state enum and output word typedef in package tdc_rx_pkg, shared with tdc_fw_core.
REQ-028 SHALL implement the buffer as sub-module tdc_rx_fifo (synchronous FWFT, one-cycle-register head, count-based full/empty).

Verification
REQ-029 SHALL cover: frame payload 24'hA5C3F0, correct parity -> FIFO_DATA=32'h01A5C3F0, FIFO_EMPTY low within 2 cycles of stop-bit strobe, counters 0.
REQ-030 SHALL cover: 10 back-to-back frames payloads 0..9, no reads, FIFO_DEPTH=8 -> 8 words 32'h01000000..32'h01000007 read in order, LOST_COUNT=2.
REQ-031 SHALL cover: stop bit sent as 1 -> no word, ERR_COUNT=1; with TDC_RX_PARITY_EN, inverted parity on 24'h000001 -> no word, ERR_COUNT=1.
REQ-032 SHALL cover: ENABLE dropped after 12 payload bits, then valid frame 24'h123456 -> only 32'h01123456 stored, ERR_COUNT=0.
REQ-033 SHALL cover: 300 framing errors then CLEAR_COUNTERS -> ERR_COUNT reads 255 before, 0 after.
REQ-034 SHALL cover: BUS_RST pulsed mid-frame with 3 words buffered -> FIFO_EMPTY=1, counters 0, next complete frame received correctly.
